// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and test-pattern generator.
// A clock divider produces a pixel enable that advances the pixel (hc) and
// line (vc) counters. hsync, vsync, active and the RGB channels are
// registered every clk from the current hc/vc, so they lag the counters by
// one clk.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   mode            0 bars, 1 checkerboard, 2 gradient, 3 solid
//   solid_rgb       {R,G,B} colour used in mode 3
//   hsync, vsync    sync outputs, active level set by HS_POL/VS_POL
//   red/green/blue  colour channels, forced to 0 in blanking
//   active          high while the current pixel is visible
//   frame_start     one-clk pulse at each frame boundary
//   frame_cnt       completed-frame counter
// Build option: define VGA_PATTERN_BORDER_EN to draw a 1-pixel all-ones
// border around the visible area.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 active,
    output logic                 frame_start,
    output logic [15:0]          frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = HW + COLOR_W;
    localparam int BAR = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0]          div;
    logic [HW-1:0]          hc;
    logic [VW-1:0]          vc;
    logic [1:0]             mode_q;
    logic [3*COLOR_W-1:0]   solid_q;

    logic                   pix_en;
    logic                   frame_end;
    logic                   active_c;
    logic                   hs_c;
    logic                   vs_c;
    logic [3*COLOR_W-1:0]   rgb_c;
    logic [3*COLOR_W-1:0]   pat_c;
    logic [HW-1:0]          bar_c;
    logic [2:0]             bar_code;
    logic [GW-1:0]          grad_c;
    logic [31:0]            hcx;
    logic [31:0]            vcx;

    assign pix_en    = (div == DIV_LAST);
    assign frame_end = pix_en && (hc == H_LAST) && (vc == V_LAST);
    assign active_c  = (hc < H_ACT) && (vc < V_ACT);
    assign hs_c      = (hc >= HS_BEG) && (hc < HS_END);
    assign vs_c      = (vc >= VS_BEG) && (vc < VS_END);
    assign hcx       = 32'(hc);
    assign vcx       = 32'(vc);

    // Gradient: hc scaled into the colour range, truncated.
    assign grad_c = {hc, COLOR_W'(0)} / GW'(H_ACTIVE);
    assign bar_c  = hc / HW'(BAR);

    always_comb begin
        bar_code = 3'd0;
        pat_c    = '0;
        // Bar index clamped so a non-multiple-of-8 width stays black.
        case ((bar_c > HW'(7)) ? 3'd7 : bar_c[2:0])
            3'd0:    bar_code = 3'b111;
            3'd1:    bar_code = 3'b110;
            3'd2:    bar_code = 3'b011;
            3'd3:    bar_code = 3'b010;
            3'd4:    bar_code = 3'b101;
            3'd5:    bar_code = 3'b100;
            3'd6:    bar_code = 3'b001;
            default: bar_code = 3'b000;
        endcase
        unique case (mode_q)
            2'd0: pat_c = {{COLOR_W{bar_code[2]}},
                           {COLOR_W{bar_code[1]}},
                           {COLOR_W{bar_code[0]}}};
            2'd1: pat_c = (hcx[5] ^ vcx[5]) ? '0 : '1;
            2'd2: pat_c = {3{grad_c[COLOR_W-1:0]}};
            2'd3: pat_c = solid_q;
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if (hc == 0 || hc == H_ACT - 1'b1 ||
            vc == 0 || vc == V_ACT - 1'b1)
            pat_c = '1;
`endif
        rgb_c = active_c ? pat_c : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            hc          <= '0;
            vc          <= '0;
            mode_q      <= 2'd0;
            solid_q     <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            div <= pix_en ? '0 : div + 1'b1;
            if (pix_en) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
            end
            // Mode only changes between frames.
            frame_start <= frame_end;
            if (frame_end) begin
                mode_q    <= mode;
                solid_q   <= solid_rgb;
                frame_cnt <= frame_cnt + 16'd1;
            end
            hsync               <= hs_c ? HS_POL : ~HS_POL;
            vsync               <= vs_c ? VS_POL : ~VS_POL;
            active              <= active_c;
            {red, green, blue}  <= rgb_c;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced 80x48 raster with CLK_DIV=2.
// Model results are queued per clk edge and compared on the next negedge.
module tb_vga_pattern_gen;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 40, VF = 2, VS = 3, VB = 3;
    localparam int CD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_rgb = 12'h000;
    logic        hsync, vsync, active, frame_start;
    logic [3:0]  red, green, blue;
    logic [15:0] frame_cnt;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(CD), .COLOR_W(4)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .active(active), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        hs, vs, act, fs;
        logic [11:0] rgb;
        logic [15:0] fc;
        int          hc, vc, md;
    } exp_t;

    exp_t q[$];

    int          m_div = 0, m_hc = 0, m_vc = 0, m_mode = 0;
    logic [11:0] m_solid = '0;
    logic [15:0] m_fc = '0;

    function automatic logic [11:0] exp_rgb(int md, logic [11:0] sol,
                                            int h, int v);
        logic [11:0] bars [8];
        int g;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        if (!(h < HA && v < VA)) return 12'h000;
`ifdef VGA_PATTERN_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)
            return 12'hFFF;
`endif
        case (md)
            0: return bars[h / (HA / 8)];
            1: return (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 12'h000 : 12'hFFF;
            2: begin
                g = (h * 16) / HA;
                return {g[3:0], g[3:0], g[3:0]};
            end
            default: return sol;
        endcase
    endfunction

    // Reference model: one expected output set per clk edge.
    always @(posedge clk) begin
        exp_t e;
        logic fe;
        if (rst) begin
            e = '{hs: 1'b0, vs: 1'b0, act: 1'b0, fs: 1'b0, rgb: '0,
                  fc: '0, hc: -1, vc: -1, md: -1};
            m_div = 0; m_hc = 0; m_vc = 0; m_mode = 0;
            m_solid = '0; m_fc = '0;
        end else begin
            fe = (m_div == CD - 1) && m_hc == HT - 1 && m_vc == VT - 1;
            e.hc  = m_hc;
            e.vc  = m_vc;
            e.md  = m_mode;
            e.act = (m_hc < HA) && (m_vc < VA);
            e.hs  = (m_hc >= HA + HF) && (m_hc < HA + HF + HS);
            e.vs  = (m_vc >= VA + VF) && (m_vc < VA + VF + VS);
            e.rgb = exp_rgb(m_mode, m_solid, m_hc, m_vc);
            e.fs  = fe;
            if (fe) begin
                m_fc    = m_fc + 16'd1;
                m_mode  = int'(mode);
                m_solid = solid_rgb;
            end
            e.fc = m_fc;
            if (m_div == CD - 1) begin
                m_div = 0;
                if (m_hc == HT - 1) begin
                    m_hc = 0;
                    m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
                end else begin
                    m_hc = m_hc + 1;
                end
            end else begin
                m_div = m_div + 1;
            end
        end
        q.push_back(e);
    end

    // Scoreboard plus fixed-value spot checks at known pixels.
    always @(negedge clk) begin
        exp_t e;
        logic [11:0] rgb;
        if (q.size() > 0) begin
            e = q.pop_front();
            rgb = {red, green, blue};
            chk("sync", {28'd0, hsync, vsync, active, frame_start},
                {28'd0, e.hs, e.vs, e.act, e.fs});
            chk("rgb", {20'd0, rgb}, {20'd0, e.rgb});
            chk("fcnt", {16'd0, frame_cnt}, {16'd0, e.fc});
`ifndef VGA_PATTERN_BORDER_EN
            if (e.md == 0 && e.vc == 10) begin
                if (e.hc == 4)  chk("bar_w", {20'd0, rgb}, 32'hFFF);
                if (e.hc == 12) chk("bar_y", {20'd0, rgb}, 32'hFF0);
                if (e.hc == 60) chk("bar_k", {20'd0, rgb}, 32'h000);
                if (e.hc == 70) chk("bar_blank", {19'd0, active, rgb}, 32'h0);
            end
            if (e.md == 1) begin
                if (e.hc == 0 && e.vc == 0)   chk("chk00", {20'd0, rgb}, 32'hFFF);
                if (e.hc == 32 && e.vc == 0)  chk("chk32_0", {20'd0, rgb}, 32'h000);
                if (e.hc == 32 && e.vc == 32) chk("chk32_32", {20'd0, rgb}, 32'hFFF);
                if (e.hc == 63 && e.vc == 31) chk("chk63_31", {20'd0, rgb}, 32'h000);
            end
            if (e.md == 2 && (e.vc == 5 || e.vc == 35)) begin
                if (e.hc == 0)  chk("grad0", {20'd0, rgb}, 32'h000);
                if (e.hc == 32) chk("grad32", {20'd0, rgb}, 32'h888);
                if (e.hc == 63) chk("grad63", {20'd0, rgb}, 32'hFFF);
            end
            if (e.md == 3 && e.vc == 5 && e.hc == 10)
                chk("solid", {20'd0, rgb}, 32'h5A3);
`else
            if (e.md == 3 && e.vc == 5) begin
                if (e.hc == 0)  chk("bord0", {20'd0, rgb}, 32'hFFF);
                if (e.hc == 1)  chk("bord1", {20'd0, rgb}, 32'h5A3);
                if (e.hc == 63) chk("bord63", {20'd0, rgb}, 32'hFFF);
            end
`endif
        end
    end

    // Sync period and width measurements; any reset invalidates them.
    int cyc = 0;
    int hs_rise = -1, hs_prev_rise = -1, vs_rise = -1, vs_fall = -1;
    logic hs_d = 1'b0, vs_d = 1'b0;
    logic [15:0] fc_at_fall = '0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hs_rise = -1; hs_prev_rise = -1; vs_rise = -1; vs_fall = -1;
        end else begin
            if (hsync && !hs_d) begin
                if (hs_rise >= 0) chk("hs_period", cyc - hs_rise, HT * CD);
                hs_rise = cyc;
            end
            if (!hsync && hs_d && hs_rise >= 0)
                chk("hs_width", cyc - hs_rise, HS * CD);
            if (vsync && !vs_d) vs_rise = cyc;
            if (!vsync && vs_d) begin
                if (vs_rise >= 0) chk("vs_width", cyc - vs_rise, HT * VS * CD);
                if (vs_fall >= 0) begin
                    chk("vs_period", cyc - vs_fall, FRAME);
                    chk("fc_step", {16'd0, frame_cnt - fc_at_fall}, 32'd1);
                end
                vs_fall = cyc;
                fc_at_fall = frame_cnt;
            end
        end
        hs_d = hsync;
        vs_d = vsync;
    end

    task automatic wait_pos(input int fc, input int vc);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (int'(m_fc) == fc && m_vc == vc) return;
        end
        chk("wait_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_pos(0, 20);
        mode = 2'd1;
        wait_pos(1, 20);
        mode = 2'd2;
        wait_pos(2, 30);
        mode = 2'd3;
        solid_rgb = 12'h5A3;
        wait_pos(3, 20);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out", {14'd0, hsync, vsync, red, green, blue, active},
            32'd0);
        chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n = 0;
        while (!vsync && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("rst_to_vsync", n, (VA + VF) * HT * CD);
        wait_pos(1, 10);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised successor to the fixed 800x600 panel display block.
- Generates VGA hsync/vsync and RGB test patterns from one system clock through an internal pixel-enable divider.
- Timing, sync polarity, clock divide and colour depth are parameters. Pattern mode is selected at run time and switches only at frame boundaries.
- Sits between the board clock/reset and the VGA pins; also provides frame markers for benches and downstream logic.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- CLK_DIV, 2, system clocks per pixel (>=1)
- COLOR_W, 4, bits per colour channel

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset
- mode  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 gradient, 3 solid
- solid_rgb  in  3*COLOR_W  solid colour {R,G,B}, used in mode 3
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red  out  COLOR_W  red channel
- green  out  COLOR_W  green channel
- blue  out  COLOR_W  blue channel
- active  out  1  high while the current pixel is visible
- frame_start  out  1  one-clock pulse at the start of each frame
- frame_cnt  out  16  completed-frame counter

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters (1040 by default); V_TOTAL = sum of the four V_* parameters (666 by default).
- Divider: div counts 0..CLK_DIV-1 every clk. pix_en is high when div == CLK_DIV-1.
- Counters: hc advances on pix_en and wraps at H_TOTAL-1 -> 0. On that wrap vc advances and wraps at V_TOTAL-1 -> 0.
- Visible region: active_c = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- hsync = HS_POL when hc is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL.
- vsync = VS_POL when vc is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else ~VS_POL.
- Outputs are registered every clk from the current hc/vc: one clk latency; each pixel is held for CLK_DIV clks.
- Blanking (active_c low): red, green and blue are 0.
- Pattern mode 0 (colour bars): 8 bars, each H_ACTIVE/8 wide, in this order: white, yellow, cyan, green, magenta, red, blue, black. Full scale = all-ones.
- Pattern mode 1 (checkerboard): white when hc[5]^vc[5] == 0, else black (32-pixel squares).
- Pattern mode 2 (gradient): all channels = (hc * 2^COLOR_W) / H_ACTIVE, truncated.
- Pattern mode 3 (solid): the latched solid_rgb value.
- Mode switching: mode and solid_rgb are latched into mode_q/solid_q only on the pix_en where hc == H_TOTAL-1 and vc == V_TOTAL-1. A change mid-frame never affects the current frame.
- Frame markers: on that same pix_en, frame_start is registered high for exactly one clk, and frame_cnt increments on the same clk, wrapping 65535 -> 0.
- Reset values: div=0, hc=0, vc=0, mode_q=0, solid_q=0, hsync=~HS_POL, vsync=~VS_POL, RGB=0, active=0, frame_start=0, frame_cnt=0.
- Reset mid-frame: all of the above apply on the next clk. Timing restarts at (0,0) after release.
- The frame immediately after reset gives no frame_start pulse. The first pulse comes at the end of the first full frame.
- Period invariant: vsync period = H_TOTAL*V_TOTAL*CLK_DIV clks (1385280 at defaults).

Optional Feature:
- Macro: VGA_PATTERN_BORDER_EN.
- Defined: a 1-pixel all-ones border is drawn on hc==0, hc==H_ACTIVE-1, vc==0 and vc==V_ACTIVE-1 inside the active region, overriding every pattern mode.
- Undefined: no border; the pattern is output unmodified.

Test Plan:
- Defaults, rst 2 clks then released -> vsync falling-to-falling = 1385280 clks; hsync period 2080 clks; hsync high 240 clks; vsync high 12480 clks; frame_cnt increments by 1 per vsync period.
- Mode 0 set before the first frame boundary, line 10 of the next frame -> pixel 50 = F,F,F; pixel 150 = F,F,0; pixel 750 = 0,0,0; pixel 900 (blanking) = 0,0,0 with active=0.
- Mode 1 -> pixel (0,0) = FFF; (32,0) = 000; (32,32) = FFF; (63,31) = 000.
- Mode 2 -> pixel hc=0 gives 0; hc=400 gives 8; hc=799 gives F on all channels.
- From mode 0, switch to mode 3 with solid_rgb=0x5A3 at line 300 -> rest of current frame stays colour bars; next frame, after frame_start, active pixels = 5,A,3.
- rst pulsed 3 clks at line 200 -> next clk: hsync=vsync=0, RGB=0, frame_cnt=0, mode_q=0. After release, first vsync assertion comes exactly (600+37)*1040*2 clks later.
- With VGA_PATTERN_BORDER_EN defined, mode 3, solid 0x000 -> pixel (0,5) = FFF; (1,5) = 000; (799,5) = FFF.
